// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the display-facing signals of seg7_scan_driver.
//   en          : display enable (low forces the display dark)
//   din[15:0]   : four BCD digits, din[3:0] = digit 0 (rightmost)
//   dp_in[3:0]  : decimal point per digit, active high
//   seg[7:0]    : shared segment bus, seg[7:1] = a..g, seg[0] = dp
//   dig_sel[3:0]: one-hot digit enable
//   frame_start : one-cycle pulse on the edge that latches a new frame
// Modports: master drives en/din/dp_in, slave (the driver) drives the rest.
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if;
  logic        en;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [7:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_start;

  modport master (
    output en, din, dp_in,
    input  seg, dig_sel, frame_start
  );

  modport slave (
    input  en, din, dp_in,
    output seg, dig_sel, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a 4-digit common-bus 7-segment display.
// Each digit owns a slot of SCAN_DIV cycles: SCAN_DIV-BLANK_CYC cycles lit,
// then BLANK_CYC cycles with everything dark to avoid ghosting. Digit data
// is latched once per frame (at digit 0) so a frame never shows a torn value.
//
// Parameters:
//   SCAN_DIV  : clk cycles per digit slot (2..65535)
//   BLANK_CYC : dead cycles at the end of each slot (1..SCAN_DIV-1)
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : seg7_scan_driver_if.slave (en, din, dp_in in; seg, dig_sel,
//         frame_start out, all outputs registered)
// Configuration:
//   SEG7_LZ_SUPPRESS_EN : when defined, leading zeros of the latched frame
//                         are blanked (digit 0 is always shown, dp kept).
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 250
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  // Counter reload values: the counter runs down to 0, so a phase of N
  // cycles is loaded with N-1.
  localparam logic [15:0] ON_LAST    = 16'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_BLANK
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [15:0] r_din;
  logic [3:0]  r_dp;
  logic [7:0]  r_seg;
  logic [7:0]  w_seg_next;
  logic [3:0]  r_dig_sel;
  logic [3:0]  w_dig_sel_next;
  logic        r_frame_start;
  logic        w_frame_start_next;

  logic        w_latch;   // this edge latches a new frame
  logic        w_show;    // next cycle is a lit ON cycle
  logic [15:0] w_src_din; // frame data the next cycle is rendered from
  logic [3:0]  w_src_dp;
  logic [3:0]  w_blank;   // per-digit leading-zero blanking
  logic [6:0]  w_glyph [4];

  function automatic logic [6:0] f_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
      default: g = 7'b0000000; // codes 10..15 render blank
    endcase
    return g;
  endfunction

  // On a latching edge the outputs for digit 0 must already reflect the new
  // data, so rendering bypasses the frame register in that case.
  assign w_src_din = w_latch ? bus.din   : r_din;
  assign w_src_dp  = w_latch ? bus.dp_in : r_dp;

`ifdef SEG7_LZ_SUPPRESS_EN
  assign w_blank[3] = (w_src_din[15:12] == 4'd0);
  assign w_blank[2] = (w_src_din[11:8]  == 4'd0) && w_blank[3];
  assign w_blank[1] = (w_src_din[7:4]   == 4'd0) && w_blank[2];
  assign w_blank[0] = 1'b0;
`else
  assign w_blank = 4'b0000;
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_glyph
      assign w_glyph[gi] = w_blank[gi] ? 7'b0000000 : f_glyph(w_src_din[gi*4 +: 4]);
    end
  endgenerate

  // Next-state / control
  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_cnt_next         = r_cnt;
    w_latch            = 1'b0;
    w_show             = 1'b0;
    w_frame_start_next = 1'b0;

    if (!bus.en) begin
      // Disable wins over everything, including a frame wrap on this edge.
      w_state_next = S_IDLE;
      w_idx_next   = 2'd0;
      w_cnt_next   = 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next       = S_ON;
          w_idx_next         = 2'd0;
          w_cnt_next         = ON_LAST;
          w_latch            = 1'b1;
          w_frame_start_next = 1'b1;
          w_show             = 1'b1;
        end
        S_ON: begin
          if (r_cnt == 16'd0) begin
            w_state_next = S_BLANK;
            w_cnt_next   = BLANK_LAST;
          end else begin
            w_cnt_next = r_cnt - 16'd1;
            w_show     = 1'b1;
          end
        end
        S_BLANK: begin
          if (r_cnt == 16'd0) begin
            w_state_next = S_ON;
            w_cnt_next   = ON_LAST;
            w_show       = 1'b1;
            if (r_idx == 2'd3) begin
              w_idx_next         = 2'd0;
              w_latch            = 1'b1;
              w_frame_start_next = 1'b1;
            end else begin
              w_idx_next = r_idx + 2'd1;
            end
          end else begin
            w_cnt_next = r_cnt - 16'd1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_idx_next   = 2'd0;
          w_cnt_next   = 16'd0;
        end
      endcase
    end
  end

  // Output decode kept outside the FSM block: the glyph path depends on
  // w_latch, which that block produces.
  assign w_seg_next     = w_show ? {w_glyph[w_idx_next], w_src_dp[w_idx_next]} : 8'h00;
  assign w_dig_sel_next = w_show ? 4'(4'b0001 << w_idx_next) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_cnt         <= 16'd0;
      r_din         <= 16'h0000;
      r_dp          <= 4'h0;
      r_seg         <= 8'h00;
      r_dig_sel     <= 4'h0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_cnt         <= w_cnt_next;
      r_seg         <= w_seg_next;
      r_dig_sel     <= w_dig_sel_next;
      r_frame_start <= w_frame_start_next;
      if (w_latch) begin
        r_din <= bus.din;
        r_dp  <= bus.dp_in;
      end
    end
  end

  assign bus.seg         = r_seg;
  assign bus.dig_sel     = r_dig_sel;
  assign bus.frame_start = r_frame_start;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a 4-digit common-bus 7-segment display. Takes four BCD digits plus decimal points, for example the stopwatch counter outputs, and drives one shared segment bus plus one-hot digit enables. Inserts a blanking interval between digits to prevent ghosting. Latches digit data once per frame so the display never shows a torn value.

Parameters:
SCAN_DIV, 12500, clk cycles per digit slot (ON + BLANK); legal range 2..65535
BLANK_CYC, 250, cycles of dead time at the end of each slot; legal range 1..SCAN_DIV-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  display enable; low forces the display dark
din  input  16  four BCD digits; din[3:0] = digit 0 (rightmost), din[15:12] = digit 3
dp_in  input  4  decimal point per digit, active high; dp_in[i] belongs to digit i
seg  output  8  shared segment bus, active high; seg[7:1] = a..g, seg[0] = dp
dig_sel  output  4  one-hot digit enable, active high; dig_sel[i] selects digit i
frame_start  output  1  one-cycle pulse on the edge that latches a new frame

Behaviour:
- Reset (async, active high): state IDLE; seg=0, dig_sel=0, frame_start=0; digit index 0; slot counter 0; latched din/dp = 0.
- Outputs are registers and update on the same clock edge as the state.
- FSM states: IDLE, ON, BLANK.
- IDLE, en=1: next edge enters ON with digit index 0. The same edge latches din and dp_in, pulses frame_start for exactly one cycle, loads the counter, and drives seg/dig_sel for digit 0.
- IDLE, en=0: all outputs stay 0.
- ON: lasts exactly SCAN_DIV-BLANK_CYC cycles. dig_sel = one-hot(index); seg = glyph of latched digit[index], with seg[0] = latched dp[index].
- ON to BLANK: seg=0, dig_sel=0 for exactly BLANK_CYC cycles.
- BLANK end, index<3: index increments and the FSM enters ON.
- BLANK end, index=3: index wraps to 0, the FSM enters ON, din/dp are re-latched, and frame_start pulses.
- Frame period = 4*SCAN_DIV cycles. frame_start pulses exactly once per frame.
- Glyphs (a..g): 0..9 use the standard patterns, e.g. 0 -> 1111110, 1 -> 0110000, 8 -> 1111111. Codes 10..15 render blank (a..g = 0); dp is still honoured.
- din changes mid-frame have no effect until the next frame latch.
- en falling (any state): next edge goes to IDLE, outputs 0, frame_start 0, index 0. The in-progress frame is abandoned.
- en rising: restarts from digit 0 with a fresh latch, per the IDLE rule.
- Reset mid-frame: outputs clear immediately (asynchronously). Operation resumes from IDLE after release.
- Simultaneous en falling and frame wrap: en wins; no frame_start pulse.
- dig_sel is never multi-hot. seg and dig_sel are both 0 in every BLANK cycle.

Optional Feature:
Macro SEG7_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression, evaluated on the latched frame. Digit 3 is blank if 0. Digit 2 is blank if 0 and digit 3 is blanked. Digit 1 is blank if 0 and digit 2 is blanked. Digit 0 is always shown. A blanked digit has a..g = 0, but its dp is still shown, and dig_sel still asserts for its slot.
- Not defined: all four digits are always rendered.

Test Plan:
- Reset/idle (SCAN_DIV=8, BLANK_CYC=2): assert rst mid-ON, hold en=0 -> seg, dig_sel and frame_start drop to 0 asynchronously and stay 0.
- Basic scan (SCAN_DIV=8, BLANK_CYC=2): din=16'h1234, dp_in=4'b0100, en=1 -> frame_start pulses every 32 cycles. Slot sequence is 6 ON cycles then 2 blank cycles. Digit 0 shows 4 (a..g 0110011, dp 0). Digit 2 shows 2 with seg[0]=1. dig_sel order is 0001, 0010, 0100, 1000.
- Frame latch: change din 1234 -> 5678 during digit 1 -> digits 2 and 3 still show 2 and 1. The next frame shows 8, 7, 6, 5.
- Invalid code: din=16'h00AF -> digits 0 and 1 have a..g = 0; digits 2 and 3 show 0 (macro off).
- en toggle: drop en during digit 2 ON -> outputs 0 on the next edge. Re-raise en -> frame_start pulses, digit 0 is displayed, a fresh latch is taken, and the full 32-cycle frame follows.
- SEG7_LZ_SUPPRESS_EN defined: din=16'h0050 -> digit 3 blank, digit 2 blank, digit 1 shows 5, digit 0 shows 0. din=16'h0000 -> only digit 0 shows 0.
